// File: rtl/gumnut_wb_sequencer_pkg.sv
// gumnut_pkg: shared widths and write-request type for the Gumnut write-back path
package gumnut_pkg;
  localparam int DATA_W = 8;
  localparam int RIDX_W = 3;
  localparam int NREGS = 8;
  typedef logic [RIDX_W-1:0] ridx_t;
  typedef struct packed {
    ridx_t rd;
    logic [DATA_W-1:0] dat;
  } wb_req_t;
endpackage

// File: rtl/gumnut_wb_sequencer_wb_fifo.sv
// wb_fifo: small load-return queue; caller guarantees no push when full and no pop when empty
module wb_fifo
  import gumnut_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  wb_req_t mem_q [DEPTH];
  wb_req_t mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rp_q];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gumnut_wb_sequencer.sv
// gumnut_wb_sequencer: arbitrates ALU results and load returns onto the register bank write port
// and tracks pending writes per register for RAW hazard detection.
module gumnut_wb_sequencer
  import gumnut_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       issue_v,
  input  logic [2:0] issue_rd,
  output logic       issue_rdy,
  input  logic       alu_v,
  input  logic [2:0] alu_rd,
  input  logic [7:0] alu_dat,
  output logic       alu_rdy,
  input  logic       mem_v,
  input  logic [2:0] mem_rd,
  input  logic [7:0] mem_dat,
  output logic       mem_rdy,
  input  logic [2:0] q_rs,
  input  logic [2:0] q_rs2,
  output logic       hazard,
  output logic       we_o,
  output logic [2:0] rd_o,
  output logic [7:0] dat_o,
  output logic       err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic full, empty, push, pop, forced, sel_v;
  wb_req_t head, sel;
  logic [SW-1:0] starve_q, starve_d;
  logic we_q, we_d, err_q, err_d;
  ridx_t rd_q, rd_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [NREGS-1:0] inc, dec;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({mem_rd, mem_dat}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign forced = (starve_q == SW'(STARVE_MAX)) && !empty;
  assign alu_rdy = cen & !forced;
  assign mem_rdy = cen & !full;
  assign issue_rdy = cen & (cnt_q[issue_rd] != CMAX);
  assign push = mem_v & mem_rdy;
  assign pop = cen & !empty & (forced | !alu_v);
  assign sel_v = pop | (alu_v & alu_rdy);
  assign sel = pop ? head : {alu_rd, alu_dat};
  assign hazard = (cnt_q[q_rs] != '0) | (cnt_q[q_rs2] != '0);
  assign inc = (issue_v & issue_rdy) ? NREGS'(1) << issue_rd : '0;
  assign dec = we_q ? NREGS'(1) << rd_q : '0;
  always_comb begin
    starve_d = starve_q;
    we_d = we_q;
    rd_d = rd_q;
    dat_d = dat_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (cen) begin
      starve_d = (pop | empty) ? '0 : starve_q + 1'b1;
      we_d = sel_v & (sel.rd != '0);
      rd_d = sel_v ? sel.rd : rd_q;
      dat_d = sel_v ? sel.dat : dat_q;
      // r0 is hardwired zero, so its counter never moves
      for (int r = 1; r < NREGS; r++) begin
        if (inc[r] && !dec[r]) cnt_d[r] = cnt_q[r] + 1'b1;
        else if (dec[r] && !inc[r]) begin
          if (cnt_q[r] == '0) err_d = 1'b1;
          else cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      we_q <= 1'b0;
      rd_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      starve_q <= starve_d;
      we_q <= we_d;
      rd_q <= rd_d;
      dat_q <= dat_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign we_o = we_q;
  assign rd_o = rd_q;
  assign dat_o = dat_q;
  assign err = err_q;
endmodule

// File: tb/tb_gumnut_wb_sequencer.sv
// tb_gumnut_wb_sequencer: directed and random stimulus against a queue-based reference model,
// with an independent monitor that scores every bank write.
module tb_gumnut_wb_sequencer;
  localparam int DEPTH = 2, SM = 4, CMAX = 3;
  logic clk = 0, rst = 1, cen = 0;
  logic issue_v = 0, alu_v = 0, mem_v = 0;
  logic [2:0] issue_rd = 0, alu_rd = 0, mem_rd = 0, q_rs = 0, q_rs2 = 0;
  logic [7:0] alu_dat = 0, mem_dat = 0;
  logic issue_rdy, alu_rdy, mem_rdy, hazard, we_o, err;
  logic [2:0] rd_o;
  logic [7:0] dat_o;

  gumnut_wb_sequencer #(.DEPTH(DEPTH), .STARVE_MAX(SM), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .issue_v(issue_v), .issue_rd(issue_rd), .issue_rdy(issue_rdy),
    .alu_v(alu_v), .alu_rd(alu_rd), .alu_dat(alu_dat), .alu_rdy(alu_rdy),
    .mem_v(mem_v), .mem_rd(mem_rd), .mem_dat(mem_dat), .mem_rdy(mem_rdy),
    .q_rs(q_rs), .q_rs2(q_rs2), .hazard(hazard),
    .we_o(we_o), .rd_o(rd_o), .dat_o(dat_o), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int rd; int dat;} wr_t;
  wr_t loads[$];
  wr_t exp_q[$];
  wr_t w;
  int cnt[8];
  int starve;
  bit m_err, m_pend, last_cen, in_rst, acc;
  int m_pend_rd;
  int checks = 0, failures = 0;
  logic prev_we;
  logic [2:0] prev_rd;
  logic [7:0] prev_dat;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Monitor: every edge with cen=1 must present exactly the write the model predicted.
  always @(negedge clk) begin
    #1;
    if (in_rst) begin
      chk("rst_we", we_o, 0);
      chk("rst_rd", rd_o, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_err", err, 0);
    end else if (last_cen) begin
      if (we_o) begin
        if (exp_q.size() == 0) chk("spurious_we", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("wr_rd", rd_o, w.rd);
          chk("wr_dat", dat_o, w.dat);
        end
      end else begin
        chk("missing_we", exp_q.size(), 0);
        exp_q.delete();
      end
      chk("err", err, m_err);
    end else begin
      chk("hold_we", we_o, prev_we);
      chk("hold_rd", rd_o, prev_rd);
      chk("hold_dat", dat_o, prev_dat);
      chk("hold_err", err, m_err);
    end
    prev_we = we_o;
    prev_rd = rd_o;
    prev_dat = dat_o;
  end

  task automatic model_reset();
    loads.delete();
    exp_q.delete();
    foreach (cnt[i]) cnt[i] = 0;
    starve = 0;
    m_err = 0;
    m_pend = 0;
    m_pend_rd = 0;
    last_cen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    {cen, issue_v, alu_v, mem_v} = '0;
    in_rst = 1;
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1;
    in_rst = 0;
  endtask

  task automatic step(input bit c, input bit iv, input int ird, input bit av, input int ard,
                      input int adat, input bit mv, input int mrd, input int mdat,
                      input int qs, input int qs2);
    bit full, was_empty, forced, e_iss, popped, have;
    int inc, dec;
    wr_t s;
    @(negedge clk);
    #2;
    cen = c;
    issue_v = iv; issue_rd = 3'(ird);
    alu_v = av; alu_rd = 3'(ard); alu_dat = 8'(adat);
    mem_v = mv; mem_rd = 3'(mrd); mem_dat = 8'(mdat);
    q_rs = 3'(qs); q_rs2 = 3'(qs2);
    #1;
    full = loads.size() == DEPTH;
    was_empty = loads.size() == 0;
    forced = starve == SM && !was_empty;
    e_iss = c && cnt[ird] != CMAX;
    chk("alu_rdy", alu_rdy, c && !forced);
    chk("mem_rdy", mem_rdy, c && !full);
    chk("issue_rdy", issue_rdy, e_iss);
    chk("hazard", hazard, cnt[qs] != 0 || cnt[qs2] != 0);
    acc = c && mv && !full;
    if (c) begin
      popped = 0;
      have = 0;
      if (!was_empty && (forced || !av)) begin
        s = loads.pop_front();
        popped = 1;
        have = 1;
      end else if (av) begin
        s = '{ard, adat};
        have = 1;
      end
      starve = (popped || was_empty) ? 0 : starve + 1;
      if (acc) loads.push_back('{mrd, mdat});
      inc = (iv && e_iss && ird != 0) ? ird : -1;
      dec = m_pend ? m_pend_rd : -1;
      if (inc != dec) begin
        if (inc >= 0) cnt[inc]++;
        if (dec >= 0) begin
          if (cnt[dec] == 0) m_err = 1;
          else cnt[dec]--;
        end
      end
      m_pend = have && s.rd != 0;
      m_pend_rd = s.rd;
      if (m_pend) exp_q.push_back(s);
    end
    last_cen = c;
  endtask

  task automatic idle(input int qs);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, qs, qs);
  endtask

  task automatic rand_step();
    step($urandom % 8 != 0, $urandom % 3 == 0, $urandom_range(0, 7),
         $urandom % 2 == 0, $urandom_range(0, 7), $urandom_range(0, 255),
         $urandom % 2 == 0, $urandom_range(0, 7), $urandom_range(0, 255),
         $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  initial begin
    int ld_rd[3] = '{4, 6, 7};
    int k;
    model_reset();
    in_rst = 0;
    #1;
    do_reset();
    for (int q = 0; q < 8; q++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, q, 7 - q);
    idle(0);
    // single RAW hazard on r3
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 3, 0);
    step(1, 0, 0, 1, 3, 8'h5A, 0, 0, 0, 3, 0);
    idle(3);
    idle(3);
    // ALU and load together
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1, 2);
    idle(2);
    idle(2);
    // starvation: ALU to r0 every cycle while loads queue up
    for (int i = 0; i < 3; i++) step(1, 1, ld_rd[i], 0, 0, 0, 0, 0, 0, 4, 6);
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 1, 0, i, k < 3, k < 3 ? ld_rd[k] : 0, 8'hA0 + k, 4, 7);
      if (acc) k++;
    end
    repeat (3) idle(6);
    // r0 write is accepted but never reaches the bank
    step(1, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0);
    idle(0);
    // counter saturation on r5, then one commit too many
    for (int i = 0; i < 4; i++) step(1, 1, 5, 0, 0, 0, 0, 0, 0, 5, 5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 5, 8'h50 + i, 0, 0, 0, 5, 5);
    repeat (3) idle(5);
    for (int i = 0; i < 300; i++) rand_step();
    do_reset();
    for (int i = 0; i < 100; i++) rand_step();
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
